// File: rtl/cla_seq_pkg.sv
// Shared types and helpers for the bit-serial (2 bits/cycle) carry-lookahead adder sequencer.
package cla_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned SLICE_W = 2;

   // Slice-counter width; never narrower than one bit, even when NSLICE = 1.
   function automatic int unsigned cnt_width(input int unsigned nslice);
      return (nslice <= 1) ? 1 : $clog2(nslice);
   endfunction

endpackage

// File: rtl/cla.sv
// 2-bit carry-lookahead adder slice: {cout, s} = a + b + cin.
module cla (
   input  logic [1:0] a,
   input  logic [1:0] b,
   input  logic       cin,
   output logic [1:0] s,
   output logic       cout
);

   logic [1:0] g;
   logic [1:0] p;
   logic       c1;

   always_comb begin
      g    = a & b;
      p    = a ^ b;
      c1   = g[0] | (p[0] & cin);
      cout = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      s    = p ^ {c1, cin};
   end

endmodule

// File: rtl/cla_serial_seq.sv
// Multi-cycle adder: feeds one 2-bit cla slice LSB-first, carry registered between slices,
// with valid/ready handshakes on operands and result.
module cla_serial_seq #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   import cla_seq_pkg::*;

   localparam int unsigned NSLICE = WIDTH / SLICE_W;
   localparam int unsigned CW     = cnt_width(NSLICE);
   localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

   if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_width_check
      $error("cla_serial_seq: WIDTH must be even and >= 2");
   end

   state_t           state;
   state_t           state_nx;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] sum_r;
   logic             cout_r;
   logic             out_valid_r;
   logic [1:0]       slice_s;
   logic             slice_c;
   logic             last;

   assign last = (cnt == LAST);

   cla u_cla (
      .a    (a_reg[SLICE_W*cnt +: SLICE_W]),
      .b    (b_reg[SLICE_W*cnt +: SLICE_W]),
      .cin  (carry),
      .s    (slice_s),
      .cout (slice_c)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid)  state_nx = RUN;
         RUN:     if (last)      state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default:                state_nx = IDLE;
      endcase
   end

   // The carry register is seeded with cin at acceptance so the first slice needs no special case.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt         <= '0;
         carry       <= 1'b0;
         a_reg       <= '0;
         b_reg       <= '0;
         sum_r       <= '0;
         cout_r      <= 1'b0;
         out_valid_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg <= a;
                  b_reg <= b;
                  carry <= cin;
                  cnt   <= '0;
               end
            end
            RUN: begin
               sum_r[SLICE_W*cnt +: SLICE_W] <= slice_s;
               carry <= slice_c;
               if (last) begin
                  cout_r      <= slice_c;
                  out_valid_r <= 1'b1;
                  cnt         <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               if (out_ready) out_valid_r <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign out_valid = out_valid_r;
   assign sum       = sum_r;
   assign cout      = cout_r;

endmodule

// File: tb/tb_cla_serial_seq.sv
// Self-checking bench for cla_serial_seq at WIDTH=8 and WIDTH=2 with a result scoreboard.
module tb_cla_serial_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n;
   logic       in_valid8, in_ready8, out_valid8, out_ready8, cin8, cout8, busy8;
   logic [7:0] a8, b8, sum8;
   logic       in_valid2, in_ready2, out_valid2, out_ready2, cin2, cout2, busy2;
   logic [1:0] a2, b2, sum2;

   int tests = 0;
   int fails = 0;
   logic [8:0] q8[$];
   logic [2:0] q2[$];

   cla_serial_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
      .sum(sum8), .cout(cout8), .busy(busy8)
   );

   cla_serial_seq #(.WIDTH(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid2), .in_ready(in_ready2),
      .a(a2), .b(b2), .cin(cin2), .out_valid(out_valid2), .out_ready(out_ready2),
      .sum(sum2), .cout(cout2), .busy(busy2)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Operands are scrambled after acceptance to show they are not resampled.
   task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c);
      int n = 0;
      while (!in_ready8 && n < 50) begin tick(); n++; end
      a8 = a; b8 = b; cin8 = c; in_valid8 = 1'b1;
      q8.push_back({1'b0, a} + {1'b0, b} + {8'd0, c});
      tick();
      in_valid8 = 1'b0;
      a8 = ~a; b8 = b ^ 8'hA5; cin8 = ~c;
   endtask

   task automatic wait_valid8(output int cyc);
      cyc = 0;
      while (!out_valid8 && cyc < 50) begin tick(); cyc++; end
   endtask

   task automatic ack8;
      out_ready8 = 1'b1;
      tick();
      out_ready8 = 1'b0;
   endtask

   task automatic send2(input logic [1:0] a, input logic [1:0] b, input logic c);
      int n = 0;
      while (!in_ready2 && n < 50) begin tick(); n++; end
      a2 = a; b2 = b; cin2 = c; in_valid2 = 1'b1;
      q2.push_back({1'b0, a} + {1'b0, b} + {2'd0, c});
      tick();
      in_valid2 = 1'b0;
      a2 = ~a; b2 = ~b; cin2 = ~c;
   endtask

   task automatic wait_valid2(output int cyc);
      cyc = 0;
      while (!out_valid2 && cyc < 50) begin tick(); cyc++; end
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      in_valid8 = 0; out_ready8 = 0; a8 = '0; b8 = '0; cin8 = 0;
      in_valid2 = 0; out_ready2 = 0; a2 = '0; b2 = '0; cin2 = 0;
      tick(); tick();
      tests++; if ({in_ready8, out_valid8, busy8, cout8, sum8} !== {4'b1000, 8'h00}) begin
         fails++; $display("FAIL reset8 got rdy/vld/busy/cout/sum=%b%b%b%b/%h want 1000/00",
                           in_ready8, out_valid8, busy8, cout8, sum8);
      end
      tests++; if ({in_ready2, out_valid2, busy2, cout2, sum2} !== 6'b100000) begin
         fails++; $display("FAIL reset2 got rdy/vld/busy/cout/sum=%b%b%b%b/%b want 1000/00",
                           in_ready2, out_valid2, busy2, cout2, sum2);
      end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_basic;
      logic [7:0] ta[3] = '{8'h5A, 8'hFF, 8'hFF};
      logic [7:0] tb[3] = '{8'h3C, 8'h01, 8'hFF};
      logic       tc[3] = '{1'b0, 1'b0, 1'b1};
      logic [8:0] want[3] = '{9'h096, 9'h100, 9'h1FF};
      logic [8:0] exp;
      int cyc;
      for (int i = 0; i < 3; i++) begin
         send8(ta[i], tb[i], tc[i]);
         tests++; if ({busy8, in_ready8} !== 2'b10) begin
            fails++; $display("FAIL basic_busy[%0d] got busy/rdy=%b%b want 10", i, busy8, in_ready8);
         end
         wait_valid8(cyc);
         tests++; if (cyc !== 4) begin
            fails++; $display("FAIL basic_latency[%0d] got %0d want 4", i, cyc);
         end
         exp = q8.pop_front();
         tests++; if ({cout8, sum8} !== want[i] || exp !== want[i]) begin
            fails++; $display("FAIL basic_sum[%0d] got %h want %h", i, {cout8, sum8}, want[i]);
         end
         ack8();
         tests++; if ({out_valid8, in_ready8, busy8} !== 3'b010) begin
            fails++; $display("FAIL basic_ack[%0d] got vld/rdy/busy=%b%b%b want 010",
                              i, out_valid8, in_ready8, busy8);
         end
      end
   endtask

   task automatic test_backpressure;
      logic [8:0] exp;
      int cyc;
      send8(8'h77, 8'h99, 1'b1);
      wait_valid8(cyc);
      exp = q8.pop_front();
      for (int i = 0; i < 5; i++) begin
         if (i == 1) begin a8 = 8'h11; b8 = 8'h22; cin8 = 0; in_valid8 = 1'b1; end
         else in_valid8 = 1'b0;
         tick();
         tests++; if ({out_valid8, in_ready8, busy8, cout8, sum8} !== {3'b101, exp}) begin
            fails++; $display("FAIL stall[%0d] got vld/rdy/busy=%b%b%b res=%h want 101 %h",
                              i, out_valid8, in_ready8, busy8, {cout8, sum8}, exp);
         end
      end
      tests++; if (exp !== 9'h111) begin
         fails++; $display("FAIL stall_model got %h want 111", exp);
      end
      in_valid8 = 1'b0;
      ack8();
      tests++; if ({out_valid8, in_ready8} !== 2'b01) begin
         fails++; $display("FAIL stall_release got vld/rdy=%b%b want 01", out_valid8, in_ready8);
      end
      repeat (8) tick();
      tests++; if (out_valid8 !== 1'b0) begin
         fails++; $display("FAIL stall_ignored got out_valid=%b want 0", out_valid8);
      end
   endtask

   task automatic test_reset_mid;
      logic [8:0] exp;
      int cyc;
      send8(8'h0F, 8'hF1, 1'b0);
      tick(); tick();
      reset_n = 1'b0;
      #1;
      tests++; if ({out_valid8, busy8, in_ready8, cout8, sum8} !== {4'b0010, 8'h00}) begin
         fails++; $display("FAIL reset_mid got vld/busy/rdy/cout/sum=%b%b%b%b/%h want 0010/00",
                           out_valid8, busy8, in_ready8, cout8, sum8);
      end
      q8.delete();
      tick();
      reset_n = 1'b1;
      repeat (6) tick();
      tests++; if (out_valid8 !== 1'b0) begin
         fails++; $display("FAIL reset_mid_noresult got out_valid=%b want 0", out_valid8);
      end
      send8(8'h80, 8'h80, 1'b0);
      wait_valid8(cyc);
      exp = q8.pop_front();
      tests++; if ({out_valid8, cout8, sum8} !== 10'b1_1_0000_0000 || exp !== 9'h100) begin
         fails++; $display("FAIL reset_mid_next got vld=%b res=%h want 1 100",
                           out_valid8, {cout8, sum8});
      end
      ack8();
   endtask

   task automatic test_width2;
      logic [4:0] v;
      logic [2:0] exp;
      int cyc;
      for (int i = 0; i < 32; i++) begin
         v = 5'(i);
         send2(v[4:3], v[2:1], v[0]);
         wait_valid2(cyc);
         tests++; if (cyc !== 1) begin
            fails++; $display("FAIL w2_latency[%0d] got %0d want 1", i, cyc);
         end
         exp = q2.pop_front();
         tests++; if ({cout2, sum2} !== exp) begin
            fails++; $display("FAIL w2_sum[%0d] got %b want %b", i, {cout2, sum2}, exp);
         end
         out_ready2 = 1'b1;
         tick();
         out_ready2 = 1'b0;
         tests++; if ({out_valid2, in_ready2} !== 2'b01) begin
            fails++; $display("FAIL w2_ack[%0d] got vld/rdy=%b%b want 01", i, out_valid2, in_ready2);
         end
      end
   endtask

   task automatic test_random;
      logic [8:0] exp;
      int cyc;
      int stall;
      for (int i = 0; i < 1000; i++) begin
         send8(8'($urandom), 8'($urandom), 1'($urandom));
         if ($urandom_range(0, 1) == 1) begin
            a8 = 8'($urandom); b8 = 8'($urandom); in_valid8 = 1'b1;
            tick();
            in_valid8 = 1'b0;
         end
         wait_valid8(cyc);
         tests++; if (out_valid8 !== 1'b1 || q8.size() != 1) begin
            fails++; $display("FAIL rand_valid[%0d] got vld=%b pending=%0d want 1 1",
                              i, out_valid8, q8.size());
         end
         exp = (q8.size() != 0) ? q8.pop_front() : 9'h000;
         stall = $urandom_range(0, 3);
         for (int s = 0; s < stall; s++) begin
            tick();
            tests++; if ({out_valid8, cout8, sum8} !== {1'b1, exp}) begin
               fails++; $display("FAIL rand_hold[%0d] got vld=%b res=%h want 1 %h",
                                 i, out_valid8, {cout8, sum8}, exp);
            end
         end
         tests++; if ({cout8, sum8} !== exp) begin
            fails++; $display("FAIL rand_sum[%0d] got %h want %h", i, {cout8, sum8}, exp);
         end
         ack8();
         tests++; if (out_valid8 !== 1'b0) begin
            fails++; $display("FAIL rand_dup[%0d] got out_valid=%b want 0", i, out_valid8);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_reset_mid();
      test_width2();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
